// File: rtl/spi_response_scheduler_if.sv
// Bundle of the scheduler's handshake, shifter-load and debug signals.
// The slave modport is the scheduler and the master modport is whatever drives it.
interface spi_response_scheduler_if;
  logic       ss;
  logic       shift_pulse;
  logic       cost_cmd;
  logic       digit_valid;
  logic [3:0] digit_in;
  logic       cost_valid;
  logic [7:0] cost_in;
  logic       digit_ack;
  logic       cost_ack;
  logic       load_en;
  logic [7:0] load_data;
  logic       busy;
  logic       overrun;
  // Debug taps: FSM state, bit counter and queue flags
  logic [2:0] dbg_state;
  logic [2:0] dbg_bit_cnt;
  logic       dbg_dig_pend;
  logic       dbg_cost_pend;
  logic       dbg_cost_armed;

  modport slave (
    input  ss, shift_pulse, cost_cmd, digit_valid, digit_in, cost_valid, cost_in,
    output digit_ack, cost_ack, load_en, load_data, busy, overrun,
    output dbg_state, dbg_bit_cnt, dbg_dig_pend, dbg_cost_pend, dbg_cost_armed
  );

  modport master (
    output ss, shift_pulse, cost_cmd, digit_valid, digit_in, cost_valid, cost_in,
    input  digit_ack, cost_ack, load_en, load_data, busy, overrun,
    input  dbg_state, dbg_bit_cnt, dbg_dig_pend, dbg_cost_pend, dbg_cost_armed
  );
endinterface

// File: rtl/spi_response_scheduler.sv
// Chooses the next SPI response (digit or cost), frames it as header+payload
// and drives the parallel load of the MISO shift register; idle-fill otherwise.
module spi_response_scheduler #(
  parameter logic [7:0] HDR_DIGIT = 8'hA1,
  parameter logic [7:0] HDR_COST  = 8'hC2,
  parameter logic [7:0] IDLE_FILL = 8'hFF
) (
  input logic                      clk,
  input logic                      rst,
  spi_response_scheduler_if.slave  bus
);

  // Handshake: digit_valid/cost_valid are always accepted; the matching ack
  // pulses one cycle later, and overrun flags a pending item that was replaced.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_HDR = 3'd1,
    SEND_HDR = 3'd2,
    LOAD_PAY = 3'd3,
    SEND_PAY = 3'd4
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] digit_hold;
  logic [7:0] cost_hold;
  logic       dig_pend, cost_pend, cost_armed;
  logic       last_cost, grant_cost;
  logic       digit_ack_r, cost_ack_r, overrun_r, load_en_r, busy_r;
  logic [7:0] load_data_r;

  logic byte_end, dig_elig, cost_elig, arb_ok, pick_cost;
  logic frame_done, dig_done, cost_done;

  always_comb begin
    byte_end   = bus.shift_pulse & ~bus.ss & (bit_cnt == 3'd7);
    dig_elig   = dig_pend;
    cost_elig  = cost_pend & cost_armed;
    // Only start a frame on a byte boundary with the master selecting us and idle
    arb_ok     = (state == IDLE) & (bit_cnt == 3'd0) & ~bus.shift_pulse & ~bus.ss;
    pick_cost  = cost_elig & (~dig_elig | ~last_cost);
    frame_done = (state == SEND_PAY) & byte_end;
    dig_done   = frame_done & ~grant_cost;
    cost_done  = frame_done & grant_cost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      digit_hold  <= 4'd0;
      cost_hold   <= 8'd0;
      dig_pend    <= 1'b0;
      cost_pend   <= 1'b0;
      cost_armed  <= 1'b0;
      last_cost   <= 1'b1;
      grant_cost  <= 1'b0;
      digit_ack_r <= 1'b0;
      cost_ack_r  <= 1'b0;
      overrun_r   <= 1'b0;
      load_en_r   <= 1'b1;
      load_data_r <= IDLE_FILL;
      busy_r      <= 1'b0;
    end else begin
      digit_ack_r <= bus.digit_valid;
      cost_ack_r  <= bus.cost_valid;
      overrun_r   <= (bus.digit_valid & dig_pend & ~dig_done) |
                     (bus.cost_valid & cost_pend & ~cost_done);

      if (bus.ss)               bit_cnt <= 3'd0;
      else if (bus.shift_pulse) bit_cnt <= bit_cnt + 3'd1;

      // A fresh capture beats the clear at frame end for the same type
      if (bus.digit_valid) begin
        digit_hold <= bus.digit_in;
        dig_pend   <= 1'b1;
      end else if (dig_done) begin
        dig_pend <= 1'b0;
      end

      if (bus.cost_valid) begin
        cost_hold <= bus.cost_in;
        cost_pend <= 1'b1;
      end else if (cost_done) begin
        cost_pend <= 1'b0;
      end

      if (bus.cost_cmd)    cost_armed <= 1'b1;
      else if (cost_done)  cost_armed <= 1'b0;

      if (state != IDLE && bus.ss) begin
        state       <= IDLE;
        load_en_r   <= 1'b1;
        load_data_r <= IDLE_FILL;
        busy_r      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            load_en_r   <= 1'b1;
            load_data_r <= IDLE_FILL;
            if (arb_ok && (dig_elig || cost_elig)) begin
              state       <= LOAD_HDR;
              grant_cost  <= pick_cost;
              load_data_r <= pick_cost ? HDR_COST : HDR_DIGIT;
              busy_r      <= 1'b1;
            end
          end
          LOAD_HDR: begin
            state     <= SEND_HDR;
            load_en_r <= 1'b0;
          end
          SEND_HDR: begin
            if (byte_end) begin
              // The payload register holds this snapshot for the whole byte
              state       <= LOAD_PAY;
              load_en_r   <= 1'b1;
              load_data_r <= grant_cost ? cost_hold : {4'h0, digit_hold};
            end
          end
          LOAD_PAY: begin
            state     <= SEND_PAY;
            load_en_r <= 1'b0;
          end
          SEND_PAY: begin
            if (byte_end) begin
              state       <= IDLE;
              last_cost   <= grant_cost;
              load_en_r   <= 1'b1;
              load_data_r <= IDLE_FILL;
              busy_r      <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            load_en_r   <= 1'b1;
            load_data_r <= IDLE_FILL;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.digit_ack      = digit_ack_r;
  assign bus.cost_ack       = cost_ack_r;
  assign bus.overrun        = overrun_r;
  assign bus.load_en        = load_en_r;
  assign bus.load_data      = load_data_r;
  assign bus.busy           = busy_r;
  assign bus.dbg_state      = state;
  assign bus.dbg_bit_cnt    = bit_cnt;
  assign bus.dbg_dig_pend   = dig_pend;
  assign bus.dbg_cost_pend  = cost_pend;
  assign bus.dbg_cost_armed = cost_armed;

endmodule

// File: tb/tb_spi_response_scheduler.sv
// Bench for spi_response_scheduler: directed frames, expected frame bytes queued
// at stimulus time and popped by an independent load monitor.
module tb_spi_response_scheduler;

  logic clk;
  logic rst;
  spi_response_scheduler_if bus();

  spi_response_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int n_dack = 0;
  int n_cack = 0;
  int n_ovr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_digit(input logic [3:0] d);
    tick();
    bus.digit_valid = 1'b1;
    bus.digit_in    = d;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic put_cost(input logic [7:0] v, input logic cmd);
    tick();
    bus.cost_valid = 1'b1;
    bus.cost_in    = v;
    bus.cost_cmd   = cmd;
    tick();
    bus.cost_valid = 1'b0;
    bus.cost_cmd   = 1'b0;
  endtask

  task automatic put_both(input logic [3:0] d, input logic [7:0] v);
    tick();
    bus.digit_valid = 1'b1;
    bus.digit_in    = d;
    bus.cost_valid  = 1'b1;
    bus.cost_in     = v;
    bus.cost_cmd    = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
    bus.cost_valid  = 1'b0;
    bus.cost_cmd    = 1'b0;
  endtask

  task automatic pulse_cmd();
    tick();
    bus.cost_cmd = 1'b1;
    tick();
    bus.cost_cmd = 1'b0;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", bus.busy, 1);
  endtask

  // Each bit: one strobe cycle followed by three quiet cycles, so load cycles never see a strobe
  task automatic pulses(input int n, input bit end_check);
    for (int i = 0; i < n; i++) begin
      tick();
      bus.shift_pulse = 1'b1;
      tick();
      bus.shift_pulse = 1'b0;
      if (end_check && (i == n - 2)) begin
        @(negedge clk);
        check("busy_before_last", bus.busy, 1);
      end
      if (end_check && (i == n - 1)) begin
        @(negedge clk);
        check("busy_after_16th", bus.busy, 0);
      end
      @(posedge clk);
      @(posedge clk);
    end
  endtask

  task automatic send_frame();
    wait_busy();
    pulses(16, 1'b1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst && bus.load_en && bus.busy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL load_byte: got=%0h expected=none at %0t", bus.load_data, $time);
      end else begin
        exp_b = exp_q.pop_front();
        check("load_byte", bus.load_data, exp_b);
      end
    end
    if (!rst && bus.digit_ack) n_dack++;
    if (!rst && bus.cost_ack)  n_cack++;
    if (!rst && bus.overrun)   n_ovr++;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b1;
    bus.ss          = 1'b0;
    bus.shift_pulse = 1'b0;
    bus.cost_cmd    = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.cost_valid  = 1'b0;
    bus.cost_in     = 8'd0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_load_en", bus.load_en, 1);
    check("rst_load_data", bus.load_data, 8'hFF);
    check("rst_busy", bus.busy, 0);
    check("rst_acks", {bus.digit_ack, bus.cost_ack, bus.overrun}, 0);
    check("rst_state", bus.dbg_state, 0);
    check("rst_bit_cnt", bus.dbg_bit_cnt, 0);
    tick();
    rst = 1'b0;

    // Single digit frame
    exp_q.push_back(8'hA1); exp_q.push_back(8'h07);
    put_digit(4'd7);
    send_frame();
    check("t1_dack", n_dack, 1);

    // Cost waits for the host command
    put_cost(8'h3C, 1'b0);
    repeat (10) tick();
    @(negedge clk);
    check("t2_no_frame_busy", bus.busy, 0);
    check("t2_idle_fill", bus.load_data, 8'hFF);
    check("t2_cost_pend", bus.dbg_cost_pend, 1);
    exp_q.push_back(8'hC2); exp_q.push_back(8'h3C);
    pulse_cmd();
    send_frame();
    @(negedge clk);
    check("t2_armed_clear", bus.dbg_cost_armed, 0);
    check("t2_cost_pend_clear", bus.dbg_cost_pend, 0);

    // Both eligible after a cost frame: digit goes first
    exp_q.push_back(8'hA1); exp_q.push_back(8'h02);
    exp_q.push_back(8'hC2); exp_q.push_back(8'h5A);
    put_both(4'd2, 8'h5A);
    send_frame();
    send_frame();

    // Overwrite before sending: one overrun, newest value goes out
    exp_q.push_back(8'hA1); exp_q.push_back(8'h05);
    tick();
    bus.digit_valid = 1'b1;
    bus.digit_in    = 4'd3;
    tick();
    bus.digit_in    = 4'd5;
    tick();
    bus.digit_valid = 1'b0;
    send_frame();
    check("t4_overrun", n_ovr, 1);

    // Both eligible after a digit frame: cost goes first
    exp_q.push_back(8'hC2); exp_q.push_back(8'h81);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h06);
    put_both(4'd6, 8'h81);
    send_frame();
    send_frame();

    // Deselect mid-frame, then the whole frame is sent again
    exp_q.push_back(8'hA1); exp_q.push_back(8'h09);
    put_digit(4'd9);
    wait_busy();
    pulses(11, 1'b0);
    tick();
    bus.ss = 1'b1;
    tick();
    @(negedge clk);
    check("t6_abort_state", bus.dbg_state, 0);
    check("t6_abort_bit_cnt", bus.dbg_bit_cnt, 0);
    check("t6_abort_busy", bus.busy, 0);
    check("t6_pend_kept", bus.dbg_dig_pend, 1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h09);
    tick();
    bus.ss = 1'b0;
    send_frame();

    // Reset during the payload byte
    put_cost(8'h77, 1'b0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h04);
    put_digit(4'd4);
    wait_busy();
    pulses(10, 1'b0);
    @(negedge clk);
    check("t7_in_send_pay", bus.dbg_state, 4);
    tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t7_load_en", bus.load_en, 1);
    check("t7_load_data", bus.load_data, 8'hFF);
    check("t7_busy", bus.busy, 0);
    check("t7_pend", {bus.dbg_dig_pend, bus.dbg_cost_pend, bus.dbg_cost_armed}, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("t7_stays_idle", bus.busy, 0);

    check("final_dack", n_dack, 7);
    check("final_cack", n_cack, 4);
    check("final_overrun", n_ovr, 1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
